// File: rtl/qupls_icache_line_assembler.sv
// qupls_icache_line_assembler
// Gathers the four 128-bit response beats of an icache line fill and emits a single
// 512-bit line write plus a one-cycle completion ack to the request generator.
// resp_tid layout: {core[5:0], channel[5:0], tranid[3:0]}.
module qupls_icache_line_assembler #(
    parameter logic [5:0] CORENO  = 6'd1,
    parameter logic [5:0] CID     = 6'd0,
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         resp_v,
    input  logic [15:0]  resp_tid,
    input  logic [31:0]  resp_adr,
    input  logic [127:0] resp_dat,
    input  logic         resp_err,
    input  logic         abort,
    output logic         wr,
    output logic [31:0]  wr_vadr,
    output logic [511:0] wr_line,
    output logic         ack,
    output logic         err
);

    typedef enum logic [1:0] {StIdle, StFill, StOut} state_e;

    state_e              state_q, state_d;
    logic [3:0]          mask_q, mask_d;
    logic                bad_q, bad_d;
    logic [7:0]          tmo_q, tmo_d;
    logic [25:0]         adr_q, adr_d;
    logic [3:0][127:0]   slot_q, slot_d;
    logic                wr_q, wr_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [511:0]        line_q, line_d;
    logic [31:0]         vadr_q, vadr_d;

    logic       accept;
    logic [1:0] idx;
    logic [3:0] beat_bit;
    logic       adr_hit;
    logic       start;
    logic       done;
    logic       done_bad;

    // Offset bits within the line carry no information for assembly.
    logic unused_adr;
    assign unused_adr = ^resp_adr[5:0];

    // Beat qualification: our core, our channel, and a tranid naming one of four beats.
    always_comb begin
        accept   = resp_v && (resp_tid[15:10] == CORENO) && (resp_tid[9:4] == CID)
                   && (resp_tid[3:2] == 2'b00);
        idx      = resp_tid[1:0];
        beat_bit = 4'b0001 << idx;
        adr_hit  = (resp_adr[31:6] == adr_q);
    end

    // State and datapath registers; slot storage needs no reset since stale data is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= 4'h0;
            bad_q   <= 1'b0;
            tmo_q   <= 8'd0;
            adr_q   <= 26'd0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            line_q  <= 512'd0;
            vadr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            bad_q   <= bad_d;
            tmo_q   <= tmo_d;
            adr_q   <= adr_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            line_q  <= line_d;
            vadr_q  <= vadr_d;
        end
        slot_q <= slot_d;
    end

    // Next-state: beat collection, timeout, completion and abort handling.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        bad_d    = bad_q;
        tmo_d    = tmo_q;
        adr_d    = adr_q;
        slot_d   = slot_q;
        wr_d     = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        line_d   = line_q;
        vadr_d   = vadr_q;
        start    = 1'b0;
        done     = 1'b0;
        done_bad = 1'b0;

        if (accept) slot_d[idx] = resp_dat;

        case (state_q)
            StIdle: begin
                if (accept) start = 1'b1;
            end
            StFill: begin
                if (accept && !adr_hit) begin
                    // Beat for a different line: drop the partial line and restart.
                    start = 1'b1;
                end else begin
                    if (accept) begin
                        mask_d = mask_q | beat_bit;
                        bad_d  = bad_q | resp_err;
                    end
                    if (mask_d == 4'hF) begin
                        done     = 1'b1;
                        done_bad = bad_d;
                    end else if (tmo_q == TIMEOUT - 8'd1) begin
                        done     = 1'b1;
                        done_bad = 1'b1;
                    end else begin
                        // Counts every fill cycle, so the limit runs from the first beat.
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            StOut: begin
                if (accept) begin
                    start = 1'b1;
                end else begin
                    state_d = StIdle;
                    mask_d  = 4'h0;
                    bad_d   = 1'b0;
                    tmo_d   = 8'd0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            adr_d   = resp_adr[31:6];
            mask_d  = beat_bit;
            bad_d   = resp_err;
            tmo_d   = 8'd0;
            state_d = StFill;
        end

        if (done) begin
            state_d = StOut;
            bad_d   = done_bad;
            wr_d    = !done_bad;
            ack_d   = 1'b1;
            err_d   = done_bad;
            line_d  = slot_d;
            vadr_d  = {adr_q, 6'b0};
        end

        // Abort wins over any beat or completion decided this cycle.
        if (abort) begin
            state_d = StIdle;
            mask_d  = 4'h0;
            bad_d   = 1'b0;
            tmo_d   = 8'd0;
            wr_d    = 1'b0;
            ack_d   = 1'b0;
            err_d   = 1'b0;
            line_d  = line_q;
            vadr_d  = vadr_q;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        wr      = wr_q;
        ack     = ack_q;
        err     = err_q;
        wr_line = line_q;
        wr_vadr = vadr_q;
    end

endmodule

// File: tb/tb_qupls_icache_line_assembler.sv
// Scoreboard bench for qupls_icache_line_assembler: a timestamp-based line model pushes
// expected completions; a negedge monitor pops and compares them when ack appears.
module tb_qupls_icache_line_assembler;

    localparam int unsigned T = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         resp_v = 1'b0;
    logic [15:0]  resp_tid = '0;
    logic [31:0]  resp_adr = '0;
    logic [127:0] resp_dat = '0;
    logic         resp_err = 1'b0;
    logic         abort = 1'b0;
    logic         wr;
    logic [31:0]  wr_vadr;
    logic [511:0] wr_line;
    logic         ack;
    logic         err;

    qupls_icache_line_assembler #(
        .CORENO (6'd1),
        .CID    (6'd0),
        .TIMEOUT(8'(T))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .resp_v  (resp_v),
        .resp_tid(resp_tid),
        .resp_adr(resp_adr),
        .resp_dat(resp_dat),
        .resp_err(resp_err),
        .abort   (abort),
        .wr      (wr),
        .wr_vadr (wr_vadr),
        .wr_line (wr_line),
        .ack     (ack),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int           cyc;
        bit           wr;
        bit           err;
        logic [31:0]  vadr;
        logic [511:0] line;
    } exp_t;
    exp_t expq[$];

    // Reference model: a line is a set of received beats, timed from its first beat.
    bit           m_active = 0;
    logic [25:0]  m_line = '0;
    logic [127:0] m_data [4];
    bit   [3:0]   m_got = '0;
    bit           m_bad = 0;
    int           m_t0 = 0;

    // Last good line the DUT should keep presenting.
    bit           last_ok = 0;
    logic [511:0] last_line = '0;
    logic [31:0]  last_vadr = '0;

    task automatic check(string name, logic [511:0] act, logic [511:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic void model_finish(int c, bit b);
        exp_t e;
        e.cyc  = c + 1;
        e.wr   = !b;
        e.err  = b;
        e.vadr = {m_line, 6'b0};
        e.line = {m_data[3], m_data[2], m_data[1], m_data[0]};
        expq.push_back(e);
        m_active = 0;
    endfunction

    function automatic void model_step(int c, bit v, logic [15:0] tid, logic [31:0] adr,
                                       logic [127:0] dat, bit e, bit ab);
        bit acc;
        int n;
        acc = v && (tid[15:10] == 6'd1) && (tid[9:4] == 6'd0) && (tid[3:2] == 2'b00);
        n   = int'(tid[1:0]);
        if (ab) begin
            m_active = 0;
            return;
        end
        if (acc && (!m_active || adr[31:6] != m_line)) begin
            m_active = 1;
            m_line   = adr[31:6];
            m_got    = '0;
            m_got[n] = 1'b1;
            m_bad    = e;
            m_data[n] = dat;
            m_t0     = c;
        end else if (acc) begin
            m_data[n] = dat;
            m_got[n]  = 1'b1;
            m_bad     = m_bad | e;
            if (m_got == 4'hF) model_finish(c, m_bad);
            else if (c - m_t0 == int'(T)) model_finish(c, 1'b1);
        end else if (m_active && (c - m_t0 == int'(T))) begin
            model_finish(c, 1'b1);
        end
    endfunction

    task automatic drive(bit v, logic [15:0] tid, logic [31:0] adr, logic [127:0] dat,
                         bit e, bit ab);
        @(posedge clk);
        #1;
        resp_v   = v;
        resp_tid = tid;
        resp_adr = adr;
        resp_dat = dat;
        resp_err = e;
        abort    = ab;
        model_step(cyc, v, tid, adr, dat, e, ab);
    endtask

    function automatic logic [15:0] mk_tid(int core, int ch, int tr);
        return {6'(core), 6'(ch), 4'(tr)};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic beat(int tr, logic [31:0] base, logic [127:0] d, bit e = 0);
        drive(1'b1, mk_tid(1, 0, tr), base + 32'(tr % 4) * 32'd16, d, e, 1'b0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        resp_v   = 1'b0;
        abort    = 1'b0;
        resp_err = 1'b0;
        m_active = 0;
        expq.delete();
        last_ok   = 1;
        last_line = '0;
        last_vadr = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_wr", 512'(wr), 512'(0));
        check("rst_ack", 512'(ack), 512'(0));
        check("rst_err", 512'(err), 512'(0));
        check("rst_line", wr_line, 512'(0));
        check("rst_vadr", 512'(wr_vadr), 512'(0));
        rst = 1'b0;
    endtask

    // Monitor: compare each completion against the scoreboard; watch for stray or late acks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ack) begin
                if (expq.size() == 0) begin
                    check("unexpected_ack", 512'(ack), 512'(0));
                end else begin
                    e = expq.pop_front();
                    check("ack_cycle", 512'(cyc), 512'(e.cyc));
                    check("wr", 512'(wr), 512'(e.wr));
                    check("err", 512'(err), 512'(e.err));
                    if (e.wr) begin
                        check("wr_vadr", 512'(wr_vadr), 512'(e.vadr));
                        check("wr_line", wr_line, e.line);
                        last_ok   = 1;
                        last_line = e.line;
                        last_vadr = e.vadr;
                    end else begin
                        last_ok = 0;
                    end
                end
            end else begin
                check("wr_without_ack", 512'(wr), 512'(0));
                if (expq.size() > 0 && expq[0].cyc < cyc) begin
                    e = expq.pop_front();
                    check("missing_ack", 512'(cyc), 512'(e.cyc));
                end
                if (last_ok) begin
                    check("hold_line", wr_line, last_line);
                    check("hold_vadr", 512'(wr_vadr), 512'(last_vadr));
                end
            end
        end
    end

    initial begin
        logic [127:0] d [4];
        logic [127:0] dd;
        int tr;
        logic [31:0] base;

        do_reset();

        // In-order fill on consecutive cycles.
        for (int i = 0; i < 4; i++) d[i] = rnd128();
        for (int i = 0; i < 4; i++) beat(i, 32'h1000, d[i]);
        idle(3);

        // Out-of-order with gaps and a duplicate of beat 0.
        for (int i = 0; i < 4; i++) d[i] = rnd128();
        dd = rnd128();
        beat(2, 32'h2000, d[2]);
        idle(1);
        beat(0, 32'h2000, d[0]);
        beat(3, 32'h2000, d[3]);
        idle(1);
        beat(0, 32'h2000, dd);
        beat(1, 32'h2000, d[1]);
        idle(3);

        // Filtering: foreign core, channel and out-of-range tranid are ignored.
        for (int i = 0; i < 4; i++) d[i] = rnd128();
        beat(0, 32'h6000, d[0]);
        drive(1'b1, mk_tid(2, 0, 1), 32'h6010, rnd128(), 1'b0, 1'b0);
        beat(1, 32'h6000, d[1]);
        drive(1'b1, mk_tid(1, 1, 2), 32'h7020, rnd128(), 1'b0, 1'b0);
        drive(1'b1, mk_tid(1, 0, 4), 32'h7000, rnd128(), 1'b0, 1'b0);
        beat(2, 32'h6000, d[2]);
        drive(1'b1, mk_tid(2, 1, 3), 32'h7030, rnd128(), 1'b0, 1'b0);
        beat(3, 32'h6000, d[3]);
        idle(3);

        // Errored beat: ack with err, no write.
        for (int i = 0; i < 4; i++) beat(i, 32'h1400, rnd128(), i == 1);
        idle(3);

        // Timeout after two beats.
        beat(0, 32'h7000, rnd128());
        beat(1, 32'h7000, rnd128());
        idle(T + 4);

        // Abort discards the partial line; the next line completes.
        beat(0, 32'h3000, rnd128());
        beat(1, 32'h3000, rnd128());
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        idle(T + 3);
        for (int i = 0; i < 4; i++) beat(i, 32'h4000, rnd128());
        idle(3);

        // Address mismatch restarts the line.
        beat(0, 32'h3000, rnd128());
        beat(1, 32'h3000, rnd128());
        for (int i = 0; i < 4; i++) beat(i, 32'h5000, rnd128());
        idle(3);

        // Back-to-back lines: line B starts in line A's output cycle.
        for (int i = 0; i < 4; i++) beat(i, 32'h8000, rnd128());
        for (int i = 0; i < 4; i++) beat(i, 32'h9000, rnd128());
        idle(3);

        // Reset mid-line: outputs clear, no ack follows.
        beat(0, 32'hC000, rnd128());
        beat(1, 32'hC000, rnd128());
        do_reset();
        idle(T + 4);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            tr   = ($urandom % 16 < 14) ? int'($urandom % 4) : 4 + int'($urandom % 12);
            base = ($urandom % 2 == 0) ? 32'hA000 : 32'hB040;
            drive(($urandom % 4) != 0,
                  mk_tid(($urandom % 8 == 0) ? 2 : 1, ($urandom % 8 == 0) ? 1 : 0, tr),
                  base + 32'(tr % 4) * 32'd16, rnd128(), ($urandom % 20) == 0,
                  ($urandom % 40) == 0);
        end
        idle(T + 5);

        check("drain_empty", 512'(expq.size()), 512'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qupls_icache_line_assembler.md
# qupls_icache_line_assembler

Collects the four 128-bit response beats of an instruction-cache line fill from the FTA response bus and delivers one 512-bit line write to the icache data/tag arrays. Sits directly downstream of the icache request generator. Produces the single-cycle `ack` that the generator waits on before it returns to waiting for the next miss. Filters responses by core/channel, tolerates out-of-order beats, and recovers from lost or errored beats.

## Interface
Parameters:
- CORENO, 6'd1, core number; only responses with `resp_tid.core==CORENO` are accepted
- CID, 6'd0, channel id; only responses with `resp_tid.channel==CID` are accepted
- TIMEOUT, 8'd64, cycles allowed from first beat to line completion

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- resp_v  in  1  response beat valid (ack/valid of the response bus)
- resp_tid  in  fta_tranid_t  core / channel / 4-bit tranid of the beat
- resp_adr  in  32  address of the beat (vadr as issued)
- resp_dat  in  128  beat data
- resp_err  in  1  bus error on this beat
- abort  in  1  snoop-kill: discard any partial line
- wr  out  1  one-cycle line write strobe to the icache
- wr_vadr  out  32  line address, `{adr[31:6],6'b0}`
- wr_line  out  512  line data; beat n occupies bits `[128n+127:128n]`
- ack  out  1  one-cycle completion pulse to the request generator
- err  out  1  qualifies `ack`: line failed; no `wr` issued

## Operation
- Beat acceptance requires all of:
  - `resp_v`
  - core match
  - channel match
  - `tranid[3:2]==0`
- Any other beat is ignored entirely.
- Beat index is `n = tranid[1:0]`. For each accepted beat:
  - the data is stored in slot n;
  - `mask[n]` is set;
  - `bad` is ORed with `resp_err`.
- Line address is `resp_adr[31:6]`. It is captured from the first beat of a line. Subsequent beats must match it.
- States: IDLE, FILL, OUT.
  - **IDLE:** an accepted beat captures the line address, `mask=1<<n`, `bad=resp_err`, `tmo=0`, and the state goes to FILL.
  - **FILL, matching-address beat:**
    - A duplicate index overwrites its slot; the mask is unchanged.
    - When the mask becomes 4'hF, the state goes to OUT.
  - **FILL, mismatched-address beat:** the partial line is discarded and the beat starts a new line (same action as IDLE, state stays FILL).
  - **FILL, no beat:** `tmo` increments. At `tmo==TIMEOUT-1` the state goes to OUT with `bad` forced to 1.
  - **OUT:**
    - `wr=!bad` for exactly one cycle.
    - `ack=1` and `err=bad` for that same cycle.
    - Next state is IDLE, or FILL if an accepted beat arrives in the OUT cycle; that beat becomes the first beat of the next line.
- `abort` asserted in any state:
  - mask, `bad` and `tmo` clear;
  - state becomes IDLE;
  - no `ack` is produced;
  - `abort` overrides a beat arriving in the same cycle (the beat is dropped).
- `abort` in the OUT cycle does not cancel that cycle's `wr`/`ack`.
- `wr_line` and `wr_vadr` hold their value after OUT until the next line completes.
- Slots not written by a beat keep stale data. This only matters when `bad=1`, in which case `wr` is 0.

## Timing
- Reset values:
  - `wr=0`, `ack=0`, `err=0`
  - `wr_line=0`, `wr_vadr=0`
  - mask=0, `tmo=0`, state IDLE
- All outputs are registered.
- Latency:
  - the fourth distinct beat is sampled at edge k;
  - `wr`/`ack` are high during cycle k+1 and low at k+2.
- With back-to-back beats on cycles 0..3, `wr` is high in cycle 4.
- Timeout: the first beat is sampled at edge j with no further beats; `ack`/`err` are high in cycle j+TIMEOUT+1.
- Throughput: one beat per cycle. A new line may begin in the OUT cycle without a bubble.
- Reset mid-fill discards the partial line. No `ack` is generated.

## Test plan
- In-order fill: beats tranid 0,1,2,3 at `adr` 0x1000,0x1010,0x1020,0x1030 with data D0..D3 on consecutive cycles -> cycle 4:
  - `wr=1`, `ack=1`, `err=0`
  - `wr_vadr=0x1000`, `wr_line={D3,D2,D1,D0}`
- Out-of-order with gaps and duplicate: beats 2,0,3,0',1 at adr 0x2000 line -> single `wr`, slot0=D0' (overwritten), one-cycle `ack` the cycle after beat 1.
- Filtering: interleave beats with core=2, or channel=1, or tranid=4, each with a valid-looking address -> ignored; the line completes only from the four matching beats; exactly one `ack`.
- Error and timeout:
  - beat 1 with `resp_err=1` -> `ack=1`, `err=1`, `wr=0` after the fourth beat;
  - separately, send only beats 0,1 with TIMEOUT=8 -> `ack`/`err` high exactly 9 cycles after the first beat.
- Abort and address mismatch:
  - beats 0,1 at 0x3000, then `abort` -> no `ack`; a following full line at 0x4000 completes normally;
  - beats 0,1 at 0x3000, then 0..3 at 0x5000 -> one `wr` with `wr_vadr=0x5000`.
- Back-to-back lines: line A 4th beat at cycle 3; line B beat 0 at cycle 4 (the OUT cycle) and beats 1..3 at 5..7 -> `wr` in cycles 4 and 8 with correct addresses; reset asserted mid-line -> all outputs 0, no `ack`.
